// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared opcodes, state encoding and control-field codes for the
//             multi-cycle MIPS control unit.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_if
//  Brief    : Opcode/memory-ready inputs and datapath control outputs of the
//             multi-cycle control unit.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] State;
    logic       Instr_done;
    logic       Illegal_op;
    logic       Mem_error;

    modport master (
        input  Opcode, Mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, State, Instr_done, Illegal_op, Mem_error
    );

    modport slave (
        output Opcode, Mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, State, Instr_done, Illegal_op, Mem_error
    );
endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Brief    : Counts consecutive memory wait cycles and flags a timeout on the
//             last permitted wait cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic wait_i,
    output logic      timeout_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    generate
        if (WAIT_LIMIT != 0) begin : g_limit
            localparam logic [7:0] C_LAST = 8'(WAIT_LIMIT - 1);
            assign timeout_o = wait_i && (cnt_q == C_LAST);
        end else begin : g_no_limit
            assign timeout_o = 1'b0;
        end
    endgenerate

    // Saturate when unlimited so an endless wait never wraps into a short one.
    always_comb begin
        cnt_d = 8'd0;
        if (wait_i && !timeout_o) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Brief    : Control FSM of the multi-cycle MIPS core with memory-ready
//             handshake, wait timeout and illegal-opcode trapping.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned WAIT_LIMIT    = 16,
    parameter int unsigned ENABLE_ADDI   = 1,
    parameter int unsigned ENABLE_J      = 1
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    multicycle_control_if.master  bus
);

    state_t state_q, state_d;
    logic   is_sw_q, is_sw_d;
    logic   illegal_q, mem_err_q, done_q;
    logic   w_set_illegal, w_retire;
    logic   w_rdy, w_in_wait, w_wait, w_timeout;
    ctrl_t  w_ctrl, w_ctrl_out;

    generate
        if (MEM_HANDSHAKE != 0) begin : g_handshake
            assign w_rdy = bus.Mem_ready;
        end else begin : g_no_handshake
            assign w_rdy = 1'b1;
        end
    endgenerate

    assign w_in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign w_wait    = w_in_wait && !w_rdy;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_timer (
        .clk       (CLK),
        .rst       (RESET),
        .wait_i    (w_wait),
        .timeout_o (w_timeout)
    );

    always_comb begin
        state_d       = state_q;
        is_sw_d       = is_sw_q;
        w_set_illegal = 1'b0;
        w_retire      = 1'b0;
        w_ctrl        = '0;
        case (state_q)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = ALUSRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = w_rdy;
                w_ctrl.pc_write  = w_rdy;
                if (w_rdy)          state_d = S_DECODE;
                else if (w_timeout) state_d = S_TRAP;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = ALUSRCB_IMMSH;
                w_ctrl.alu_op    = ALUOP_ADD;
                // Remember lw/sw here: the opcode is not trusted after DECODE.
                is_sw_d = (bus.Opcode == OP_SW);
                if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (bus.Opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (bus.Opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if ((ENABLE_J != 0) && (bus.Opcode == OP_J)) begin
                    state_d = S_JUMP;
                end else if ((ENABLE_ADDI != 0) && (bus.Opcode == OP_ADDI)) begin
                    state_d = S_ADDIEX;
                end else begin
                    state_d       = S_TRAP;
                    w_set_illegal = 1'b1;
                end
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUSRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                if (w_rdy)          state_d = S_MEMWB;
                else if (w_timeout) state_d = S_TRAP;
            end
            S_MEMWB: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                if (w_rdy) begin
                    state_d  = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUSRCB_REG;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = ALUSRCB_REG;
                w_ctrl.alu_op        = ALUOP_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCSRC_JUMP;
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALUSRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_ctrl.reg_write = 1'b1;
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d       = S_TRAP;
                w_set_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            is_sw_q   <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_sw_q   <= is_sw_d;
            illegal_q <= illegal_q | w_set_illegal;
            mem_err_q <= mem_err_q | w_timeout;
            done_q    <= w_retire;
        end
    end

    assign w_ctrl_out = RESET ? '0 : w_ctrl;

    assign bus.PCWrite     = w_ctrl_out.pc_write;
    assign bus.PCWriteCond = w_ctrl_out.pc_write_cond;
    assign bus.IorD        = w_ctrl_out.iord;
    assign bus.MemRead     = w_ctrl_out.mem_read;
    assign bus.MemWrite    = w_ctrl_out.mem_write;
    assign bus.IRWrite     = w_ctrl_out.ir_write;
    assign bus.MemtoReg    = w_ctrl_out.mem_to_reg;
    assign bus.RegDst      = w_ctrl_out.reg_dst;
    assign bus.RegWrite    = w_ctrl_out.reg_write;
    assign bus.ALUSrcA     = w_ctrl_out.alu_src_a;
    assign bus.ALUSrcB     = w_ctrl_out.alu_src_b;
    assign bus.ALUOp       = w_ctrl_out.alu_op;
    assign bus.PCSource    = w_ctrl_out.pc_source;
    assign bus.State       = state_q;
    assign bus.Instr_done  = done_q    & ~RESET;
    assign bus.Illegal_op  = illegal_q & ~RESET;
    assign bus.Mem_error   = mem_err_q & ~RESET;

endmodule
`default_nettype wire
